// File: rtl/mat_stream_if.sv
// mat_stream_if: operand write port, start strobe and skew-stage vector outputs of mat_stream.
interface mat_stream_if #(parameter int M = 3);
  localparam int W = $clog2(M);
  logic         wr_en;
  logic         wr_sel;
  logic [W-1:0] wr_row;
  logic [W-1:0] wr_col;
  logic [7:0]   wr_data;
  logic         start;
  logic [7:0]   a_vec [0:M-1];
  logic [7:0]   b_vec [0:M-1];
  logic         valid;
  logic         busy;
  logic         done;
  modport master (output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
                  input  a_vec, b_vec, valid, busy, done);
  modport slave  (input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
                  output a_vec, b_vec, valid, busy, done);
endinterface

// File: rtl/mat_stream.sv
// mat_stream: holds two MxM operand matrices and streams A columns / B rows into a systolic array, then drains it.
module mat_stream #(
  parameter int M     = 3,
  parameter int FLUSH = 2 * M - 1
) (
  input logic          CLK,
  input logic          RST_N,
  mat_stream_if.slave  bus
);
  localparam int W  = $clog2(M);
  localparam int FW = $clog2(FLUSH + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  logic [1:0]    state;
  logic [W-1:0]  t;
  logic [FW-1:0] fc;
  logic [7:0]    a_mem [0:M-1][0:M-1];
  logic [7:0]    b_mem [0:M-1][0:M-1];
  logic          accept;
  logic          wr_ok;
  logic          t_last;
  logic          fc_last;
  // busy stays high through the done cycle, so it also masks starts and writes there
  always_comb begin
    accept  = bus.start && state == S_IDLE && !bus.busy;
    wr_ok   = bus.wr_en && !bus.busy && ({1'b0, bus.wr_row} < (W+1)'(M)) && ({1'b0, bus.wr_col} < (W+1)'(M));
    t_last  = t == W'(M - 1);
    fc_last = fc == FW'(FLUSH - 1);
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
    end else if (wr_ok) begin
      if (bus.wr_sel) b_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
      else a_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  // outputs trail the state by one edge: the step-t vector is registered while state is STREAM at t
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state     <= S_IDLE;
      t         <= '0;
      fc        <= '0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      for (int i = 0; i < M; i++) begin
        bus.a_vec[i] <= '0;
        bus.b_vec[i] <= '0;
      end
    end else begin
      state <= state == S_IDLE   ? (accept  ? S_STREAM : S_IDLE) :
               state == S_STREAM ? (t_last  ? S_FLUSH  : S_STREAM) :
               state == S_FLUSH  ? (fc_last ? S_DONE   : S_FLUSH) : S_IDLE;
      t         <= (state == S_STREAM && !t_last) ? t + 1'b1 : '0;
      fc        <= (state == S_FLUSH && !fc_last) ? fc + 1'b1 : '0;
      bus.valid <= state == S_STREAM;
      bus.done  <= state == S_DONE;
      bus.busy  <= accept || (bus.busy && !bus.done);
      for (int i = 0; i < M; i++) begin
        bus.a_vec[i] <= (state == S_STREAM) ? a_mem[i][t] : '0;
        bus.b_vec[i] <= (state == S_STREAM) ? b_mem[t][i] : '0;
      end
    end
endmodule

// File: doc/mat_stream.md
MAT_STREAM -- requirements
Module: mat_stream

Interface
REQ-001: Parameter M, default 3, matrix dimension (M x M operands, M lanes per output vector); legal range 2..16.
REQ-002: Parameter FLUSH, default 2*M-1, number of zero-drive cycles after the data phase so the skewed array drains.
REQ-003: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004: RST_N  input  1  reset, asynchronous, active-low.
REQ-005: wr_en  input  1  operand write strobe.
REQ-006: wr_sel  input  1  operand select: 0 = matrix A, 1 = matrix B.
REQ-007: wr_row  input  $clog2(M)  row index of the write.
REQ-008: wr_col  input  $clog2(M)  column index of the write.
REQ-009: wr_data  input  8  unsigned operand element.
REQ-010: start  input  1  single-cycle request to begin streaming.
REQ-011: a_vec  output  8 x [0:M-1]  unpacked array; lane i drives row i of the systolic array (into the row-skew stage).
REQ-012: b_vec  output  8 x [0:M-1]  unpacked array; lane j drives column j of the systolic array (into the column-skew stage).
REQ-013: valid  output  1  high during the data phase only.
REQ-014: busy  output  1  high from the cycle after an accepted start until the cycle done is asserted, inclusive.
REQ-015: done  output  1  single-cycle pulse at the end of a run.

Function
REQ-016: Storage: two M x M 8-bit register arrays, A and B; wr_en=1 and busy=0 writes wr_data to A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1) at the clock edge.
REQ-017: Writes with wr_en=1 while busy=1 are dropped; storage is unchanged.
REQ-018: Writes with an index >= M are dropped (relevant when M is not a power of two).
REQ-019: The FSM has 4 states: IDLE, STREAM, FLUSH, DONE.
REQ-020: IDLE -> STREAM on start=1; start in any other state is ignored.
REQ-021: A counter t runs 0..M-1 in STREAM. STREAM -> FLUSH when t=M-1.
REQ-022: A counter runs 0..FLUSH-1 in FLUSH. FLUSH -> DONE when the count reaches FLUSH-1.
REQ-023: DONE -> IDLE unconditionally after one cycle.
REQ-024: In STREAM at step t, a_vec[i] = A[i][t] and b_vec[j] = B[t][j] for all i, j (registered outputs), and valid = 1.
REQ-025: In IDLE, FLUSH and DONE, a_vec and b_vec are all zero and valid = 0.
REQ-026: Latency: start sampled at edge k; first vector (t=0) is visible after edge k+1; the last vector is visible after edge k+M.
REQ-027: done is high for exactly one cycle, the cycle after edge k+M+FLUSH+1.
REQ-028: Total run length from start to done is M+FLUSH+1 cycles.
REQ-029: A write and a start in the same cycle while IDLE: the write commits, and the run uses the updated value.
REQ-030: A start in the same cycle as done=1 is ignored; a new start is accepted from IDLE on the next cycle.
REQ-031: Operand storage is preserved across runs; repeated starts stream identical data.

Reset
REQ-032: RST_N=0 asynchronously forces state to IDLE, clears both counters, and sets a_vec, b_vec, valid, busy and done to 0.
REQ-033: RST_N=0 clears A and B to all zeros.
REQ-034: Reset asserted mid-run aborts the run immediately; done is not produced.
REQ-035: After RST_N deassertion, the first start is honoured no earlier than the first clock edge on which RST_N=1.

Verification (M=3, FLUSH=5)
REQ-036: Write A=[[1,2,3],[4,5,6],[7,8,9]] and B = identity, pulse start -> over 3 valid cycles a_vec = {1,4,7}, {2,5,8}, {3,6,9} and b_vec = {1,0,0}, {0,1,0}, {0,0,1}; then 5 zero cycles; done 9 cycles after start.
REQ-037: During a run, write A[0][0]=99 and pulse start again -> the write is ignored, the run length is unchanged, and a second run after done streams a_vec[0]=1 at t=0.
REQ-038: Write A[2][2]=200 with wr_sel=0 in the same cycle as start -> a_vec[2]=200 at t=2.
REQ-039: Assert RST_N=0 at t=1 of STREAM -> all outputs are 0 immediately, no done follows, and a run after reset streams all zeros.
REQ-040: Pulse start in the same cycle as done, then start again on the next cycle -> only the second start launches a run; busy stays low for exactly one cycle between the runs.
REQ-041: Back-to-back runs with no writes in between -> identical a_vec/b_vec sequences, and valid is high exactly 3 cycles per run.
